// File: rtl/alu_exec_unit_if.sv
// Execute-stage bus: decode controls and operands in, registered ALU results out.
interface alu_exec_unit_if #(
  parameter int WIDTH = 32
) ();
  logic [1:0]              alu_op;
  logic [5:0]              funct;
  logic                    ctrl_sel;
  logic [3:0]              ctrl_direct;
  logic signed [WIDTH-1:0] data_in0;
  logic signed [WIDTH-1:0] data_in1;
  logic                    branch;
  logic [WIDTH-1:0]        result;
  logic                    zero;
  logic                    overflow;
  logic [3:0]              operation;
  logic                    branch_taken;

  modport master (
    output alu_op, funct, ctrl_sel, ctrl_direct, data_in0, data_in1, branch,
    input  result, zero, overflow, operation, branch_taken
  );

  modport slave (
    input  alu_op, funct, ctrl_sel, ctrl_direct, data_in0, data_in1, branch,
    output result, zero, overflow, operation, branch_taken
  );
endinterface

// File: rtl/alu_exec_unit.sv
// MIPS execute stage: ALU-control decode, 32-bit ALU with zero/overflow flags
// and the branch AND gate, all outputs registered (one cycle latency).
module alu_exec_unit #(
  parameter int WIDTH = 32
) (
  input logic            clk,
  input logic            rst,
  alu_exec_unit_if.slave bus
);
  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_NOR = 4'b1100;
  localparam logic [3:0] OP_BAD = 4'b1111;

  function automatic logic [3:0] decodeOp(input logic [1:0] aluOp, input logic [5:0] fn);
    logic [3:0] op;
    case (aluOp)
      2'b00:   op = OP_ADD;
      2'b01:   op = OP_SUB;
      2'b11:   op = OP_ADD;
      default: begin
        case (fn)
          6'b100000: op = OP_ADD;
          6'b100001: op = OP_ADD;
          6'b100010: op = OP_SUB;
          6'b100100: op = OP_AND;
          6'b100101: op = OP_OR;
          6'b100111: op = OP_NOR;
          6'b101010: op = OP_SLT;
          default:   op = OP_BAD;
        endcase
      end
    endcase
    return op;
  endfunction

  // Signed overflow of A + B': operands agree in sign but the sum does not.
  function automatic logic addOverflow(input logic aSign, input logic bSign, input logic rSign);
    return (aSign == bSign) && (rSign != aSign);
  endfunction

  logic [3:0]              opCode_p0;
  logic signed [WIDTH-1:0] bPrime_p0;
  logic signed [WIDTH-1:0] sum_p0;
  logic signed [WIDTH-1:0] aluRes_p0;
  logic                    ovf_p0;
  logic                    zero_p0;

  // Stage p0: decode and combinational ALU
  always_comb begin
    opCode_p0 = bus.ctrl_sel ? bus.ctrl_direct : decodeOp(bus.alu_op, bus.funct);
    bPrime_p0 = (opCode_p0 == OP_SUB) ? -bus.data_in1 : bus.data_in1;
    sum_p0    = bus.data_in0 + bPrime_p0;
    aluRes_p0 = '0;
    ovf_p0    = 1'b0;
    case (opCode_p0)
      OP_AND: aluRes_p0 = bus.data_in0 & bus.data_in1;
      OP_OR:  aluRes_p0 = bus.data_in0 | bus.data_in1;
      OP_NOR: aluRes_p0 = ~(bus.data_in0 | bus.data_in1);
      OP_SLT: aluRes_p0 = {{(WIDTH-1){1'b0}}, (bus.data_in0 < bus.data_in1)};
      OP_ADD, OP_SUB: begin
        aluRes_p0 = sum_p0;
        ovf_p0    = addOverflow(bus.data_in0[WIDTH-1], bPrime_p0[WIDTH-1], sum_p0[WIDTH-1]);
      end
      default: aluRes_p0 = '0;
    endcase
    zero_p0 = (aluRes_p0 == '0);
  end

  // Stage p1: output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.result       <= '0;
      bus.zero         <= 1'b0;
      bus.overflow     <= 1'b0;
      bus.operation    <= 4'b0000;
      bus.branch_taken <= 1'b0;
    end else begin
      bus.result       <= aluRes_p0;
      bus.zero         <= zero_p0;
      bus.overflow     <= ovf_p0;
      bus.operation    <= opCode_p0;
      bus.branch_taken <= bus.branch & zero_p0;
    end
  end
endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed and randomized bench for alu_exec_unit with an expected-result queue.
module tb_alu_exec_unit;
  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  alu_exec_unit_if #(.WIDTH(32)) bus ();

  alu_exec_unit #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic        z;
    logic        ov;
    logic [3:0]  op;
    logic        bt;
    string       tag;
  } exp_t;

  exp_t sb[$];

  function automatic exp_t mk(input string tag, input logic [31:0] res, input logic z,
                              input logic ov, input logic [3:0] op, input logic bt);
    exp_t e;
    e.tag = tag; e.res = res; e.z = z; e.ov = ov; e.op = op; e.bt = bt;
    return e;
  endfunction

  // Reference model written from the operation table, using 64-bit arithmetic for overflow.
  function automatic exp_t model(input logic [1:0] aop, input logic [5:0] fn, input logic cs,
                                 input logic [3:0] cd, input logic [31:0] a, input logic [31:0] b,
                                 input logic br);
    exp_t e;
    logic [3:0]  op;
    logic [31:0] r;
    logic [31:0] bp;
    logic [63:0] fullBits;
    longint      full;
    logic        ov;
    if (cs) op = cd;
    else if (aop == 2'b01) op = 4'b0110;
    else if (aop != 2'b10) op = 4'b0010;
    else if (fn == 6'h20 || fn == 6'h21) op = 4'b0010;
    else if (fn == 6'h22) op = 4'b0110;
    else if (fn == 6'h24) op = 4'b0000;
    else if (fn == 6'h25) op = 4'b0001;
    else if (fn == 6'h27) op = 4'b1100;
    else if (fn == 6'h2A) op = 4'b0111;
    else op = 4'b1111;
    r = 32'd0; ov = 1'b0;
    if (op == 4'b0010 || op == 4'b0110) begin
      bp = (op == 4'b0110) ? (~b + 32'd1) : b;
      full = longint'($signed(a)) + longint'($signed(bp));
      fullBits = full;
      r = fullBits[31:0];
      ov = (full > 64'sd2147483647) || (full < -64'sd2147483648);
    end else if (op == 4'b0000) r = a & b;
    else if (op == 4'b0001) r = a | b;
    else if (op == 4'b1100) r = ~(a | b);
    else if (op == 4'b0111) r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
    e = mk("rand", r, (r == 32'd0), ov, op, br & (r == 32'd0));
    return e;
  endfunction

  task automatic checkOut();
    exp_t e;
    checks++;
    assert (sb.size() > 0) else begin
      errors++;
      $error("FAIL scoreboard_empty got %0d exp >0", sb.size());
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      assert (bus.result === e.res) else begin
        errors++; $error("FAIL %s.result got %h exp %h", e.tag, bus.result, e.res);
      end
      checks++;
      assert (bus.zero === e.z) else begin
        errors++; $error("FAIL %s.zero got %b exp %b", e.tag, bus.zero, e.z);
      end
      checks++;
      assert (bus.overflow === e.ov) else begin
        errors++; $error("FAIL %s.overflow got %b exp %b", e.tag, bus.overflow, e.ov);
      end
      checks++;
      assert (bus.operation === e.op) else begin
        errors++; $error("FAIL %s.operation got %b exp %b", e.tag, bus.operation, e.op);
      end
      checks++;
      assert (bus.branch_taken === e.bt) else begin
        errors++; $error("FAIL %s.branch_taken got %b exp %b", e.tag, bus.branch_taken, e.bt);
      end
    end
  endtask

  task automatic step(input logic r, input logic [1:0] aop, input logic [5:0] fn,
                      input logic cs, input logic [3:0] cd, input logic [31:0] a,
                      input logic [31:0] b, input logic br, input exp_t e);
    rst             = r;
    bus.alu_op      = aop;
    bus.funct       = fn;
    bus.ctrl_sel    = cs;
    bus.ctrl_direct = cd;
    bus.data_in0    = a;
    bus.data_in1    = b;
    bus.branch      = br;
    sb.push_back(e);
    @(posedge clk);
    #1;
    checkOut();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  aop;
    logic [5:0]  fn;
    logic [31:0] a, b;
    logic        br;
    logic [5:0]  fnTab [8];
    fnTab = '{6'h20, 6'h21, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A, 6'h03};

    rst = 1'b1;
    bus.alu_op = 2'b00; bus.funct = 6'h0; bus.ctrl_sel = 1'b0; bus.ctrl_direct = 4'h0;
    bus.data_in0 = 32'd5; bus.data_in1 = 32'd7; bus.branch = 1'b1;
    @(negedge clk);

    // Reset holds every output at zero even with live operands.
    step(1'b1, 2'b00, 6'h00, 1'b0, 4'h0, 32'd5, 32'd7, 1'b1, mk("reset1", 32'd0, 1'b0, 1'b0, 4'b0000, 1'b0));
    step(1'b1, 2'b00, 6'h00, 1'b0, 4'h0, 32'd5, 32'd7, 1'b1, mk("reset2", 32'd0, 1'b0, 1'b0, 4'b0000, 1'b0));
    step(1'b0, 2'b00, 6'h00, 1'b0, 4'h0, 32'd5, 32'd7, 1'b0, mk("release", 32'd12, 1'b0, 1'b0, 4'b0010, 1'b0));

    step(1'b0, 2'b10, 6'h20, 1'b0, 4'h0, 32'd5, 32'd7, 1'b0, mk("add_funct", 32'd12, 1'b0, 1'b0, 4'b0010, 1'b0));
    step(1'b0, 2'b01, 6'h00, 1'b0, 4'h0, 32'h1234, 32'h1234, 1'b1, mk("beq_eq", 32'd0, 1'b1, 1'b0, 4'b0110, 1'b1));
    step(1'b0, 2'b01, 6'h00, 1'b0, 4'h0, 32'h1234, 32'h1235, 1'b1, mk("beq_ne", 32'hFFFFFFFF, 1'b0, 1'b0, 4'b0110, 1'b0));
    step(1'b0, 2'b10, 6'h2A, 1'b0, 4'h0, 32'hFFFFFFFF, 32'd1, 1'b0, mk("slt_neg", 32'd1, 1'b0, 1'b0, 4'b0111, 1'b0));
    step(1'b0, 2'b10, 6'h2A, 1'b0, 4'h0, 32'd1, 32'hFFFFFFFF, 1'b0, mk("slt_swap", 32'd0, 1'b1, 1'b0, 4'b0111, 1'b0));
    step(1'b0, 2'b10, 6'h22, 1'b0, 4'h0, 32'h12345678, 32'h12345678, 1'b1, mk("bt_sub_rtype", 32'd0, 1'b1, 1'b0, 4'b0110, 1'b1));
    step(1'b0, 2'b00, 6'h00, 1'b1, 4'b0010, 32'h7FFFFFFF, 32'd1, 1'b0, mk("direct_ovf", 32'h80000000, 1'b0, 1'b1, 4'b0010, 1'b0));
    step(1'b0, 2'b00, 6'h00, 1'b1, 4'b0010, 32'h00003000, 32'd4, 1'b0, mk("pc_plus4", 32'h00003004, 1'b0, 1'b0, 4'b0010, 1'b0));
    step(1'b0, 2'b10, 6'h00, 1'b0, 4'h0, 32'd3, 32'd3, 1'b0, mk("bad_funct", 32'd0, 1'b1, 1'b0, 4'b1111, 1'b0));
    step(1'b0, 2'b10, 6'h22, 1'b0, 4'h0, 32'h80000000, 32'd1, 1'b0, mk("sub_ovf", 32'h7FFFFFFF, 1'b0, 1'b1, 4'b0110, 1'b0));
    step(1'b0, 2'b10, 6'h21, 1'b0, 4'h0, 32'h7FFFFFFF, 32'd1, 1'b0, mk("addu_ovf", 32'h80000000, 1'b0, 1'b1, 4'b0010, 1'b0));
    step(1'b0, 2'b10, 6'h24, 1'b0, 4'h0, 32'hF0F0FF00, 32'h0FF0F0F0, 1'b0, mk("and", 32'h00F0F000, 1'b0, 1'b0, 4'b0000, 1'b0));
    step(1'b0, 2'b10, 6'h25, 1'b0, 4'h0, 32'hF0F0FF00, 32'h0FF0F0F0, 1'b0, mk("or", 32'hFFF0FFF0, 1'b0, 1'b0, 4'b0001, 1'b0));
    step(1'b0, 2'b10, 6'h27, 1'b0, 4'h0, 32'hF0F0FF00, 32'h0FF0F0F0, 1'b0, mk("nor", 32'h000F000F, 1'b0, 1'b0, 4'b1100, 1'b0));
    step(1'b0, 2'b11, 6'h22, 1'b0, 4'h0, 32'd40, 32'd2, 1'b0, mk("aluop11", 32'd42, 1'b0, 1'b0, 4'b0010, 1'b0));
    step(1'b0, 2'b10, 6'h22, 1'b1, 4'b0000, 32'hFF00FF00, 32'h0F0F0F0F, 1'b0, mk("direct_and", 32'h0F000F00, 1'b0, 1'b0, 4'b0000, 1'b0));
    step(1'b0, 2'b00, 6'h00, 1'b1, 4'b0011, 32'd9, 32'd9, 1'b1, mk("direct_unused", 32'd0, 1'b1, 1'b0, 4'b0011, 1'b1));
    step(1'b0, 2'b10, 6'h20, 1'b0, 4'h0, 32'd1, 32'd1, 1'b1, mk("reset_mid_pre", 32'd2, 1'b0, 1'b0, 4'b0010, 1'b0));
    step(1'b1, 2'b10, 6'h20, 1'b0, 4'h0, 32'd1, 32'd1, 1'b1, mk("reset_mid", 32'd0, 1'b0, 1'b0, 4'b0000, 1'b0));

    for (int i = 0; i < 24; i++) begin
      aop = 2'($urandom_range(0, 3));
      fn  = fnTab[$urandom_range(0, 7)];
      a   = $urandom;
      b   = (i % 4 == 0) ? a : $urandom;
      br  = 1'($urandom_range(0, 1));
      step(1'b0, aop, fn, 1'b0, 4'h0, a, b, br, model(aop, fn, 1'b0, 4'h0, a, b, br));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
